mmio_timer_led: RTL and testbench
=================================

MMIO_TIMER_LED -- requirements
Module: mmio_timer_led

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0400, word-aligned base of the 32-byte register window.
REQ-002 SHALL have parameter PRESCALE, default 50000, clocks per timer tick (>=2).
REQ-003 SHALL have port sys_clk, input, 1, single clock for all state.
REQ-004 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port daddr, input, 32, CPU data byte address.
REQ-006 SHALL have port din, input, 32, CPU write data (big-endian CPU view).
REQ-007 SHALL have port MemWrite, input, 1, CPU write strobe.
REQ-008 SHALL have port dout, output, 32, read data (combinational).
REQ-009 SHALL have port hit, output, 1, daddr is inside the window; top gates RAM we and muxes dout with it.
REQ-010 SHALL have port led_r, output, 1, red LED.
REQ-011 SHALL have port led_g, output, 1, green LED.
REQ-012 SHALL have port irq, output, 1, timer-match interrupt.

Function
REQ-013 SHALL assert hit iff daddr[31:5] == BASE_ADDR[31:5]; register index is daddr[4:2]; daddr[1:0] is ignored.
REQ-014 SHALL define registers: 0 CTRL{bit0 TEN, bit1 AUTO, bit2 BLINK, bit3 IEN}; 1 LED{bit0 R, bit1 G}; 2 CMP; 3 CNT; 4 STATUS{bit0 MATCH, W1C}; 5-7 read 0, writes ignored.
REQ-015 SHALL commit a write on the rising sys_clk edge when MemWrite && hit, and ignore MemWrite when hit is low.
REQ-016 SHALL drive dout combinationally from the addressed register with zero latency, and drive 0 when hit is low.
REQ-017 SHALL run the prescaler 0..PRESCALE-1 only while TEN=1, pulse tick for one cycle on wrap, and clear the prescaler when TEN is written 0.
REQ-018 SHALL increment CNT by 1 on each tick, wrapping 32'hFFFF_FFFF to 0.
REQ-019 SHALL treat a tick where CNT == CMP as a match: set MATCH; if AUTO=1 load CNT to 0 and continue; if AUTO=0 hold CNT and clear TEN.
REQ-020 SHALL let a CPU write to CNT or CTRL override the tick update in the same cycle.
REQ-021 SHALL let a MATCH set win over a same-cycle W1C clear.
REQ-022 SHALL drive LEDs from the LED register when BLINK=0.
REQ-023 SHALL, when BLINK=1, step a blink FSM on each match: OFF(r0,g0) -> RED(r1,g0) -> GREEN(r0,g1) -> BOTH(r1,g1) -> OFF.
REQ-024 SHALL return the blink FSM to OFF when BLINK is written 0.
REQ-025 SHALL drive all outputs from registers, except dout and hit.

Reset
REQ-026 SHALL on sys_rst_n low asynchronously clear CTRL, LED, CMP, CNT, STATUS, the prescaler, and the FSM (state OFF).
REQ-027 SHALL hold led_r=0, led_g=0, irq=0 while in reset, with dout=0 when hit is low.
REQ-028 SHALL abandon any mid-count tick on reset, and restart the first tick PRESCALE clocks after TEN is set.

Configuration
REQ-029 SHALL, with MMIO_TIMER_IRQ_EN defined, drive irq = MATCH & IEN as a register output with CTRL bit3 read/write.
REQ-030 SHALL, without MMIO_TIMER_IRQ_EN, tie irq to 0, make CTRL bit3 read 0, and ignore writes to CTRL bit3.

Structure
REQ-031 SHALL place register index constants, CTRL/STATUS bit positions and the blink-state enum blink_state_t (OFF, RED, GREEN, BOTH) in package mmio_pkg.
REQ-032 SHALL implement the prescaler as sub-module mmio_prescaler (ports sys_clk, sys_rst_n, en, tick).

Verification
REQ-033 SHALL cover: PRESCALE=4, write CMP=3, CTRL=3 (TEN|AUTO) -> MATCH set 16 clocks after enable; CNT reads 0 next cycle; repeats every 16 clocks.
REQ-034 SHALL cover: AUTO=0, CMP=2, TEN=1 -> after match CNT holds 2, CTRL reads TEN=0, no further ticks.
REQ-035 SHALL cover: write STATUS=1 in the same cycle as a match -> MATCH stays 1; a W1C one cycle later -> MATCH 0.
REQ-036 SHALL cover: BLINK=1 with four matches -> (led_r,led_g) = 10, 01, 11, 00; then BLINK=0 with LED=2 -> led_g=1, led_r=0.
REQ-037 SHALL cover: MemWrite=1 with daddr=32'h0000_0008 -> hit=0, no register changes, dout=0; read of daddr=BASE+0x14 -> 0.
REQ-038 SHALL cover: with MMIO_TIMER_IRQ_EN, IEN=1 and a match -> irq=1 the cycle after MATCH sets; sys_rst_n pulsed low mid-count -> irq, CNT, leds 0 immediately.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared register map, bit positions and blink-state encoding for the MMIO timer/LED block.
package mmio_pkg;
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_LED    = 3'd1;
  localparam logic [2:0] REG_CMP    = 3'd2;
  localparam logic [2:0] REG_CNT    = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam int CTRL_TEN     = 0;
  localparam int CTRL_AUTO    = 1;
  localparam int CTRL_BLINK   = 2;
  localparam int CTRL_IEN     = 3;
  localparam int STATUS_MATCH = 0;
  localparam int LED_R        = 0;
  localparam int LED_G        = 1;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RED   = 2'd1,
    GREEN = 2'd2,
    BOTH  = 2'd3
  } blink_state_t;

  function automatic blink_state_t blink_next(input blink_state_t s);
    case (s)
      OFF:     return RED;
      RED:     return GREEN;
      GREEN:   return BOTH;
      default: return OFF;
    endcase
  endfunction
endpackage

// File: rtl/mmio_prescaler.sv
// Free-running 0..PRESCALE-1 divider; held at zero while disabled, tick marks the wrap cycle.
module mmio_prescaler #(
  parameter int PRESCALE = 50000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic en,
  output logic tick
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;

  assign tick = en && (pcnt_q == LAST);

  always_comb begin
    pcnt_d = pcnt_q + PW'(1);
    if (!en || tick) pcnt_d = '0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) pcnt_q <= '0;
    else            pcnt_q <= pcnt_d;
  end
endmodule

// File: rtl/mmio_timer_led.sv
// Memory-mapped timer with compare match, blink sequencer and LED drive.
// Define MMIO_TIMER_IRQ_EN to enable CTRL.IEN and the registered irq output.
module mmio_timer_led
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int          PRESCALE  = 50000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] daddr,
  input  logic [31:0] din,
  input  logic        MemWrite,
  output logic [31:0] dout,
  output logic        hit,
  output logic        led_r,
  output logic        led_g,
  output logic        irq
);
  logic [2:0]   idx;
  logic         we, tick, match;
  logic [3:0]   ctrl_q, ctrl_d;
  logic [1:0]   led_q, led_d;
  logic [31:0]  cmp_q, cmp_d, cnt_q, cnt_d;
  logic         match_q, match_d;
  logic         led_r_q, led_r_d, led_g_q, led_g_d;
  blink_state_t bst_q, bst_d;
  logic [1:0]   unused_addr;

  assign unused_addr = daddr[1:0];
  assign hit   = (daddr[31:5] == BASE_ADDR[31:5]);
  assign idx   = daddr[4:2];
  assign we    = MemWrite && hit;
  assign match = tick && (cnt_q == cmp_q);

  mmio_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .en       (ctrl_q[CTRL_TEN]),
    .tick     (tick)
  );

  always_comb begin
    ctrl_d  = ctrl_q;
    led_d   = led_q;
    cmp_d   = cmp_q;
    cnt_d   = cnt_q;
    match_d = match_q;
    if (tick) begin
      if (!match)                 cnt_d = cnt_q + 32'd1;
      else if (ctrl_q[CTRL_AUTO]) cnt_d = '0;
      else                        ctrl_d[CTRL_TEN] = 1'b0;
    end
    // CPU writes land after the timer update so they take precedence
    if (we) begin
      case (idx)
        REG_CTRL:   ctrl_d = din[3:0];
        REG_LED:    led_d  = din[1:0];
        REG_CMP:    cmp_d  = din;
        REG_CNT:    cnt_d  = din;
        REG_STATUS: if (din[STATUS_MATCH]) match_d = 1'b0;
        default:    ;
      endcase
    end
    if (match) match_d = 1'b1;
`ifndef MMIO_TIMER_IRQ_EN
    ctrl_d[CTRL_IEN] = 1'b0;
`endif
  end

  always_comb begin
    bst_d = bst_q;
    if (!ctrl_d[CTRL_BLINK])            bst_d = OFF;
    else if (match && ctrl_q[CTRL_BLINK]) bst_d = blink_next(bst_q);
    led_r_d = ctrl_d[CTRL_BLINK] ? (bst_d == RED   || bst_d == BOTH) : led_d[LED_R];
    led_g_d = ctrl_d[CTRL_BLINK] ? (bst_d == GREEN || bst_d == BOTH) : led_d[LED_G];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ctrl_q  <= '0;
      led_q   <= '0;
      cmp_q   <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
      bst_q   <= OFF;
      led_r_q <= 1'b0;
      led_g_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      led_q   <= led_d;
      cmp_q   <= cmp_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      bst_q   <= bst_d;
      led_r_q <= led_r_d;
      led_g_q <= led_g_d;
    end
  end

  assign led_r = led_r_q;
  assign led_g = led_g_q;

`ifdef MMIO_TIMER_IRQ_EN
  logic irq_q, irq_d;
  assign irq_d = match_q & ctrl_q[CTRL_IEN];
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) irq_q <= 1'b0;
    else            irq_q <= irq_d;
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    dout = '0;
    if (hit) begin
      case (idx)
        REG_CTRL:   dout = {28'b0, ctrl_q};
        REG_LED:    dout = {30'b0, led_q};
        REG_CMP:    dout = cmp_q;
        REG_CNT:    dout = cnt_q;
        REG_STATUS: dout = {31'b0, match_q};
        default:    dout = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_timer_led.sv
// Directed bench for mmio_timer_led with PRESCALE=4; all stimulus driven and sampled on negedges.
module tb_mmio_timer_led;
  localparam logic [31:0] BASE = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] daddr, din, dout;
  logic        mem_write, hit, led_r, led_g, irq;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] rv;
  logic [1:0]  blink_exp [4];

  mmio_timer_led #(.BASE_ADDR(BASE), .PRESCALE(4)) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .daddr    (daddr),
    .din      (din),
    .MemWrite (mem_write),
    .dout     (dout),
    .hit      (hit),
    .led_r    (led_r),
    .led_g    (led_g),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; commits on the next posedge and returns on the following negedge.
  task automatic wr_a(input logic [31:0] a, input logic [31:0] d);
    daddr = a; din = d; mem_write = 1'b1;
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  task automatic wr(input int r, input logic [31:0] d);
    wr_a(BASE + 32'(r * 4), d);
  endtask

  task automatic rd_a(input logic [31:0] a, output logic [31:0] d);
    daddr = a;
    #1 d = dout;
  endtask

  task automatic rd(input int r, output logic [31:0] d);
    rd_a(BASE + 32'(r * 4), d);
  endtask

  task automatic waitn(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    blink_exp[0] = 2'b10; blink_exp[1] = 2'b01; blink_exp[2] = 2'b11; blink_exp[3] = 2'b00;
    rst_n = 1'b0; daddr = '0; din = '0; mem_write = 1'b0;

    // reset state
    @(negedge clk);
    #1;
    chk("rst_leds", {30'b0, led_r, led_g}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_dout_miss", dout, 32'h0);
    rd(0, rv); chk("rst_ctrl", rv, 32'h0);
    rd(3, rv); chk("rst_cnt", rv, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // auto-reload, match every 16 clocks, W1C vs same-cycle set
    wr(2, 32'd3);
    wr(0, 32'h3);
    waitn(15);
    rd(4, rv); chk("auto_status_pre", rv, 32'h0);
    rd(3, rv); chk("auto_cnt_pre", rv, 32'd3);
    waitn(1);
    rd(4, rv); chk("auto_status_hit", rv, 32'h1);
    rd(3, rv); chk("auto_cnt_reload", rv, 32'h0);
    chk("auto_irq_off", {31'b0, irq}, 32'h0);
    wr(4, 32'h1);
    rd(4, rv); chk("w1c_clear", rv, 32'h0);
    waitn(14);
    rd(4, rv); chk("auto2_status_pre", rv, 32'h0);
    wr(4, 32'h1);
    rd(4, rv); chk("w1c_vs_set", rv, 32'h1);
    rd(3, rv); chk("auto2_cnt", rv, 32'h0);
    wr(4, 32'h1);
    rd(4, rv); chk("w1c_late", rv, 32'h0);
    wr(0, 32'h0);

    // one-shot: hold CNT, clear TEN
    wr(3, 32'd0);
    wr(2, 32'd2);
    wr(0, 32'h1);
    waitn(11);
    rd(4, rv); chk("once_status_pre", rv, 32'h0);
    rd(3, rv); chk("once_cnt_pre", rv, 32'd2);
    waitn(1);
    rd(4, rv); chk("once_status", rv, 32'h1);
    rd(3, rv); chk("once_cnt_hold", rv, 32'd2);
    rd(0, rv); chk("once_ctrl_ten0", rv, 32'h0);
    waitn(20);
    rd(3, rv); chk("once_no_ticks", rv, 32'd2);
    wr(4, 32'h1);

    // blink sequence, every tick matches with CMP=0
    wr(3, 32'd0);
    wr(2, 32'd0);
    wr(0, 32'h7);
    chk("blink_start", {30'b0, led_r, led_g}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      waitn(4);
      chk($sformatf("blink_%0d", i), {30'b0, led_r, led_g}, {30'b0, blink_exp[i]});
    end
    wr(0, 32'h0);
    chk("blink_off", {30'b0, led_r, led_g}, 32'h0);
    wr(1, 32'h2);
    chk("led_reg_g", {30'b0, led_r, led_g}, 32'h1);
    wr(4, 32'h1);

    // address decode
    daddr = 32'h0000_0008; din = 32'h55; mem_write = 1'b1;
    #1;
    chk("miss_hit", {31'b0, hit}, 32'h0);
    chk("miss_dout", dout, 32'h0);
    @(negedge clk);
    mem_write = 1'b0;
    rd(2, rv); chk("miss_no_write", rv, 32'h0);
    wr(2, 32'hA5A5_0001);
    rd_a(BASE + 32'h0B, rv); chk("low_bits_ignored", rv, 32'hA5A5_0001);
    wr(5, 32'hFFFF_FFFF);
    rd_a(BASE + 32'h14, rv); chk("reg5_reads0", rv, 32'h0);
    rd_a(BASE + 32'h14, rv); chk("reg5_hit", {31'b0, hit}, 32'h1);

    // irq, then asynchronous reset mid-count
    wr(1, 32'h3);
    wr(3, 32'd0);
    wr(2, 32'd2);
    wr(4, 32'h1);
    wr(0, 32'hB);
    waitn(11);
    rd(4, rv); chk("irq_status_pre", rv, 32'h0);
    waitn(1);
    rd(4, rv); chk("irq_status", rv, 32'h1);
    chk("irq_lag", {31'b0, irq}, 32'h0);
    waitn(1);
`ifdef MMIO_TIMER_IRQ_EN
    chk("irq_set", {31'b0, irq}, 32'h1);
    rd(0, rv); chk("ctrl_ien_rw", rv, 32'hB);
`else
    chk("irq_tied", {31'b0, irq}, 32'h0);
    rd(0, rv); chk("ctrl_ien_ro", rv, 32'h3);
`endif
    waitn(5);
    rd(3, rv); chk("pre_rst_cnt", rv, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_irq", {31'b0, irq}, 32'h0);
    chk("arst_leds", {30'b0, led_r, led_g}, 32'h0);
    rd(3, rv); chk("arst_cnt", rv, 32'h0);
    rd(4, rv); chk("arst_status", rv, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // first tick arrives PRESCALE clocks after TEN
    wr(0, 32'h1);
    waitn(3);
    rd(4, rv); chk("restart_pre", rv, 32'h0);
    waitn(1);
    rd(4, rv); chk("restart_tick", rv, 32'h1);
    rd(0, rv); chk("restart_ten0", rv, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
